// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - borrow_in, LSB first,
// one full-subtractor step per clock with a start/busy/done handshake.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sr_q, sr_d, diff_q, diff_d;
    logic             br_q, br_d, borrow_q, borrow_d, ovf_q, ovf_d;
    logic             ai, bi, d_bit, br_nxt, last_bit;

    // Single full-subtractor cell on the current bit position
    always_comb begin
        ai       = a_q[cnt_q];
        bi       = b_q[cnt_q];
        d_bit    = ai ^ bi ^ br_q;
        br_nxt   = (~ai & bi) | (~(ai ^ bi) & br_q);
        last_bit = (cnt_q == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        sr_d     = sr_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d   = a;
                    b_d   = b;
                    br_d  = borrow_in;
                    cnt_d = '0;
                    sr_d  = '0;
                end
            end
            RUN: begin
                br_d  = br_nxt;
                sr_d  = {d_bit, sr_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                // Results are published only on the edge that enters DONE
                if (last_bit) begin
                    diff_d   = {d_bit, sr_q[WIDTH-1:1]};
                    borrow_d = br_nxt;
                    ovf_d    = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (d_bit ^ a_q[WIDTH-1]);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            sr_q     <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            sr_q     <= sr_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    assign diff     = diff_q;
    assign borrow   = borrow_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases, start-while-busy,
// mid-operation reset, random W=8 and exhaustive W=4 against an arithmetic model.
module tb_serial_subtractor;
    logic       clk;
    logic       rst_n;
    logic       start8, bin8, busy8, done8, bor8, ovf8;
    logic [7:0] a8, b8, diff8;
    logic       start4, bin4, busy4, done4, bor4, ovf4;
    logic [3:0] a4, b4, diff4;
    int         tests;
    int         fails;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .borrow_in(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow(bor8), .overflow(ovf8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .borrow_in(bin4),
        .busy(busy4), .done(done4), .diff(diff4), .borrow(bor4), .overflow(ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arithmetic reference: plain integer subtraction, unsigned and signed views
    function automatic void model(input int w, input int a, input int b, input int bin,
                                  output int d, output bit br, output bit ov);
        int r, sa, sb, sr;
        r  = a - b - bin;
        d  = r & ((1 << w) - 1);
        br = (r < 0);
        sa = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
        sb = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
        sr = sa - sb - bin;
        ov = (sr < -(1 << (w - 1))) || (sr > (1 << (w - 1)) - 1);
    endfunction

    // Drive one W=8 operation; lat = negedges after the load edge until done (bounded)
    task automatic do_op8(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                          output int lat);
        @(negedge clk);
        a8 = ia; b8 = ib; bin8 = ibin; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = $urandom; b8 = $urandom; bin8 = $urandom;
        lat = 0;
        while (!done8 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_op4(input logic [3:0] ia, input logic [3:0] ib, input logic ibin,
                          output int lat);
        @(negedge clk);
        a4 = ia; b4 = ib; bin4 = ibin; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        lat = 0;
        while (!done4 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({busy8, done8, diff8, bor8, ovf8} !== 12'h0) begin
            fails++;
            $display("FAIL reset_w8 got busy=%b done=%b diff=%h bor=%b ovf=%b want all 0",
                     busy8, done8, diff8, bor8, ovf8);
        end
        tests++;
        if ({busy4, done4, diff4, bor4, ovf4} !== 8'h0) begin
            fails++;
            $display("FAIL reset_w4 got busy=%b done=%b diff=%h bor=%b ovf=%b want all 0",
                     busy4, done4, diff4, bor4, ovf4);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [7:0] va [7];
        logic [7:0] vb [7];
        logic       vc [7];
        logic [7:0] ed [7];
        logic       eb [7];
        logic       eo [7];
        int         lat;
        va = '{8'h35, 8'h00, 8'h80, 8'h7F, 8'h10, 8'h00, 8'hFF};
        vb = '{8'h12, 8'h01, 8'h01, 8'hFF, 8'h0F, 8'h00, 8'hFF};
        vc = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0};
        ed = '{8'h23, 8'hFF, 8'h7F, 8'h80, 8'h00, 8'hFF, 8'h00};
        eb = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0};
        eo = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0};
        for (int i = 0; i < 7; i++) begin
            do_op8(va[i], vb[i], vc[i], lat);
            tests++;
            if (lat !== 8 || diff8 !== ed[i] || bor8 !== eb[i] || ovf8 !== eo[i]) begin
                fails++;
                $display("FAIL directed_%0d got lat=%0d diff=%h bor=%b ovf=%b want lat=8 diff=%h bor=%b ovf=%b",
                         i, lat, diff8, bor8, ovf8, ed[i], eb[i], eo[i]);
            end
            @(negedge clk);
            tests++;
            if (done8 !== 1'b0 || busy8 !== 1'b0 || diff8 !== ed[i]) begin
                fails++;
                $display("FAIL after_done_%0d got done=%b busy=%b diff=%h want 0 0 %h",
                         i, done8, busy8, diff8, ed[i]);
            end
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        @(negedge clk);
        a8 = 8'h50; b8 = 8'h20; bin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        tests++;
        if (busy8 !== 1'b1) begin
            fails++;
            $display("FAIL busy_after_load got %b want 1", busy8);
        end
        repeat (2) @(negedge clk);
        a8 = 8'h01; b8 = 8'h00; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        lat = 3;
        while (!done8 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        tests++;
        if (lat !== 8 || diff8 !== 8'h30 || bor8 !== 1'b0 || ovf8 !== 1'b0) begin
            fails++;
            $display("FAIL ignore_start got lat=%0d diff=%h bor=%b ovf=%b want lat=8 diff=30 0 0",
                     lat, diff8, bor8, ovf8);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat, d;
        bit br, ov;
        logic [7:0] ra, rb;
        // Each op starts on the cycle right after the previous done
        for (int i = 0; i < 3; i++) begin
            ra = $urandom; rb = $urandom;
            a8 = ra; b8 = rb; bin8 = 1'b1; start8 = 1'b1;
            @(negedge clk);
            start8 = 1'b0;
            lat = 0;
            while (!done8 && lat < 40) begin
                @(negedge clk);
                lat++;
            end
            model(8, int'(ra), int'(rb), 1, d, br, ov);
            tests++;
            if (lat !== 8 || diff8 !== d[7:0] || bor8 !== br || ovf8 !== ov) begin
                fails++;
                $display("FAIL back_to_back_%0d got lat=%0d diff=%h bor=%b ovf=%b want lat=8 diff=%h bor=%b ovf=%b",
                         i, lat, diff8, bor8, ovf8, d[7:0], br, ov);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        int lat;
        do_op8(8'h80, 8'h01, 1'b0, lat);
        @(negedge clk);
        a8 = 8'h33; b8 = 8'h11; bin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tests++;
        if ({busy8, done8, diff8, bor8, ovf8} !== 12'h0) begin
            fails++;
            $display("FAIL reset_mid got busy=%b done=%b diff=%h bor=%b ovf=%b want all 0",
                     busy8, done8, diff8, bor8, ovf8);
        end
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (done8 || busy8) seen++;
        end
        tests++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL reset_mid_no_done got %0d active cycles want 0", seen);
        end
    endtask

    task automatic test_random();
        int lat, d;
        bit br, ov;
        logic [7:0] ra, rb;
        logic       rc;
        int         bad;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            ra = $urandom; rb = $urandom; rc = $urandom;
            do_op8(ra, rb, rc, lat);
            model(8, int'(ra), int'(rb), int'(rc), d, br, ov);
            tests++;
            if (lat !== 8 || diff8 !== d[7:0] || bor8 !== br || ovf8 !== ov) begin
                fails++;
                bad++;
                if (bad < 6)
                    $display("FAIL random a=%h b=%h bin=%b got lat=%0d diff=%h bor=%b ovf=%b want diff=%h bor=%b ovf=%b",
                             ra, rb, rc, lat, diff8, bor8, ovf8, d[7:0], br, ov);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_exhaustive_w4();
        int lat, d;
        bit br, ov;
        int bad;
        bad = 0;
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                for (int c = 0; c < 2; c++) begin
                    do_op4(4'(x), 4'(y), 1'(c), lat);
                    model(4, x, y, c, d, br, ov);
                    tests++;
                    if (lat !== 4 || diff4 !== d[3:0] || bor4 !== br || ovf4 !== ov) begin
                        fails++;
                        bad++;
                        if (bad < 6)
                            $display("FAIL w4 a=%h b=%h bin=%0d got lat=%0d diff=%h bor=%b ovf=%b want diff=%h bor=%b ovf=%b",
                                     x, y, c, lat, diff4, bor4, ovf4, d[3:0], br, ov);
                    end
                    @(negedge clk);
                end
    endtask

    initial begin
        tests = 0; fails = 0;
        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
        test_reset();
        test_directed();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_exhaustive_w4();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
